// File: rtl/uart_pkg.sv
// Shared types and constants for the serial UART transmitter.
// The even-parity helper is used only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separately held occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_serial.sv
// Byte-buffered 8N1 serial transmitter with a programmable baud divider.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_serial
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  BAUD_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 frame_tail_q;
    logic                 bit_end;
    logic                 pop;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_rdata;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign bit_end  = (baud_q == BAUD_MAX);
    assign tx       = tx_q;
    // frame_tail_q covers the cycle where the last stop bit is still in the tx register.
    assign busy     = (state_q != IDLE) || !fifo_empty || frame_tail_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE:  pop = !fifo_empty;
            START: if (bit_end) begin
                state_d   = DATA;
                bit_idx_d = '0;
            end
            DATA: if (bit_end) begin
                shift_d   = shift_q >> 1;
                bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (bit_idx_q == LAST_BIT) state_d = PARITY;
`else
                if (bit_idx_q == LAST_BIT) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) begin
                if (!fifo_empty) pop     = 1'b1;
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = fifo_rdata;
            state_d = START;
            baud_d  = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(fifo_rdata);
`endif
        end
    end

    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        case (state_q)
            START:  tx_d = ~UART_IDLE_LEVEL;
            DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_q;
`endif
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            tx_q         <= UART_IDLE_LEVEL;
            frame_tail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            frame_tail_q <= (state_q != IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end
`endif

endmodule

// File: tb/tb_uart_tx_serial.sv
// Self-checking bench for uart_tx_serial: scoreboard of pushed bytes checked by a tx-line decoder.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_serial;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC  = FRAME_BITS * CLK_DIV;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         frames_seen = 0;
    int         max_count = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_serial #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Expected tx level rel cycles after the accepting edge of a byte pushed into an idle DUT.
    function automatic logic frame_level(input logic [7:0] b, input int rel);
        int idx;
        if (rel < 2 || rel >= 2 + FRAME_CYC) return 1'b1;
        idx = (rel - 2) / CLK_DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Offer a byte (called just after a negedge); returns just after the accepting edge's negedge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        else           exp_q.push_back(b);
        @(negedge clk);
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || !tx) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_not_busy"}, busy, 0);
        repeat (4) @(negedge clk);
    endtask

    // Decode frames from the tx line by sampling mid-bit; abandons a frame if rst rises.
    initial begin : monitor
        logic [FRAME_BITS-1:0] bits;
        logic                  ok;
        int                    s;
        logic [7:0]            exp_b;
        forever begin
            @(negedge clk);
            if (!rst && tx == 1'b0) begin
                s    = cyc;
                ok   = 1'b1;
                bits = '0;
                for (int i = 0; i < FRAME_BITS; i++) begin
                    for (int k = 0; k < ((i == 0) ? CLK_DIV / 2 : CLK_DIV); k++) begin
                        @(negedge clk);
                        if (rst) ok = 1'b0;
                        if (!ok) break;
                    end
                    if (!ok) break;
                    bits[i] = tx;
                end
                for (int k = 0; ok && k < CLK_DIV - CLK_DIV / 2 - 1; k++) begin
                    @(negedge clk);
                    if (rst) ok = 1'b0;
                end
                if (ok) begin
                    frames_seen++;
                    starts.push_back(s);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", exp_q.size(), 1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("start_bit", bits[0], 0);
                        check("data_byte", bits[8:1], exp_b);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", bits[9], ^exp_b);
`endif
                        check("stop_bit", bits[FRAME_BITS-1], 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int bad;
        int t0;
        int n0;
        int acc[10];

        // Asynchronous reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_async_tx", tx, 1);
        check("rst_async_count", fifo_count, 0);
        check("rst_async_ready", in_ready, 1);
        check("rst_async_busy", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0) bad++;
        end
        check("idle_hold_bad_cycles", bad, 0);

        // Single byte: exact cycle-by-cycle waveform and busy release.
        starts.delete();
        send(8'h55);
        t0 = cyc;
        check("count_after_push", fifo_count, 1);
        for (int rel = 1; rel <= FRAME_CYC + 2; rel++) begin
            @(negedge clk);
            check("single_tx", tx, frame_level(8'h55, rel));
            if (rel == 1)             check("count_after_pop", fifo_count, 0);
            if (rel == FRAME_CYC + 1) check("busy_last_stop", busy, 1);
            if (rel == FRAME_CYC + 2) check("busy_fall", busy, 0);
        end
        wait_idle("single", 200);

        // Back-to-back: second start bit immediately follows first stop bit.
        starts.delete();
        send(8'h41);
        send(8'h42);
        wait_idle("b2b", 400);
        check("b2b_frames", starts.size(), 2);
        if (starts.size() == 2) check("b2b_gap", starts[1] - starts[0], FRAME_CYC);

        // Full FIFO: in_valid held for bytes 0..9.
        max_count = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'(i));
            acc[i] = cyc;
        end
        check("full_peak_count", max_count, FIFO_DEPTH);
        check("full_byte8_accept", acc[8] - acc[0], 8);
        check("full_byte9_accept", acc[9] - acc[0], FRAME_CYC + 2);
        wait_idle("full", 1500);

        // Reset mid-frame during data bit 3 of 0x00 with three bytes queued.
        n0 = frames_seen;
        send(8'h00);
        t0 = cyc;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        while (cyc < t0 + 2 + 4 * CLK_DIV + 1) @(negedge clk);
        check("pre_rst_tx_low", tx, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);
        check("post_rst_frames", frames_seen, n0);

`ifdef UART_TX_PARITY_EN
        starts.delete();
        send(8'h07);
        send(8'h03);
        wait_idle("parity", 400);
        check("parity_frames", starts.size(), 2);
        if (starts.size() == 2) check("parity_frame_len", starts[1] - starts[0], 11 * CLK_DIV);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_serial.md
Name: uart_tx_serial

Overview:
- Downstream consumer of the character stream produced by the AXI-Lite UART slave: each byte the slave accepts is pushed here instead of being printed by simulation.
- Buffers bytes in a small synchronous FIFO and serializes them onto a single `tx` line as 8N1 frames (start bit, 8 data bits LSB-first, stop bit), with a programmable clock divider.
- Sits between the UART slave and the top-level pad or sim UART monitor.

Parameters:
- CLK_DIV, 16: clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8: byte FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte offered by the upstream UART slave.
- in_ready  output  1  FIFO can accept a byte; equals !full.
- in_data  input  8  byte to transmit.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high while state != IDLE or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-high; one clock domain.
- On rst assertion, immediately (no clock edge needed):
  - tx=1, state=IDLE, FIFO pointers and count = 0, in_ready=1, busy=0.
  - Baud counter and bit counter = 0.
  - A frame in progress is abandoned with no stop bit; the FIFO contents are discarded.
- Push rule:
  - Push happens when in_valid && in_ready at a clk edge.
  - in_ready is low when count==FIFO_DEPTH, even if a pop occurs in the same cycle. There is no combinational ready-through-pop path.
- Pop rule: pop happens in IDLE when the FIFO is non-empty, or on the last cycle of the stop bit when the FIFO is non-empty. On a pop:
  - The head byte loads into the 8-bit shift register.
  - state becomes START and the baud counter clears.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- FSM states: IDLE, START, DATA, STOP, plus PARITY under the optional feature.
  - IDLE: tx=1.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0]. Every CLK_DIV cycles, shift right and increment bit_idx. After bit_idx==7 completes, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end, go to START if the FIFO is non-empty (pop), else IDLE.
- tx is registered from state and shift register, so it changes exactly on bit boundaries.
- Baud counter counts 0..CLK_DIV-1. The bit boundary is at count==CLK_DIV-1; the counter then wraps to 0.
- Latency: byte accepted at edge N with FIFO empty and IDLE gives pop at N+1 and tx falling at edge N+2.
- Frame length is 10*CLK_DIV cycles. Back-to-back frames have zero idle gap.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
- count is held separately and saturates at neither bound; illegal states are unreachable because ready and empty gating prevent them.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits, captured at pop) for CLK_DIV cycles.
  - Frame length becomes 11*CLK_DIV cycles.
- When undefined: no PARITY state and no parity register; behaviour is exactly 8N1 as above.

Decomposition:
- Shared package uart_pkg:
  - state typedef: 3-bit encoding IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - UART_DATA_BITS=8.
  - UART_IDLE_LEVEL=1'b1.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push/pop/full/empty/count, asynchronous active-high reset.
  - Instantiated with WIDTH=8, DEPTH=FIFO_DEPTH.
- The FSM, baud counter and shift register stay in uart_tx_serial.

Test Plan:
- Reset idle: hold rst 3 cycles, release → tx=1, in_ready=1, busy=0, fifo_count=0 for 100 cycles.
- Single byte, CLK_DIV=4, push 0x55 at edge 10:
  - tx=0 during cycles 12-15.
  - Then 1,0,1,0,1,0,1,0, each 4 cycles (16-47).
  - Stop 1 during 48-51.
  - busy falls at 52.
- Back-to-back, CLK_DIV=4: push 0x41 then 0x42 on consecutive cycles → second start bit begins the cycle after the first stop bit ends (gap=0); total 80 tx cycles.
- Full FIFO, FIFO_DEPTH=8, CLK_DIV=4, in_valid held with bytes 0..9:
  - Bytes 0..8 accepted; fifo_count peaks at 8.
  - in_ready stays low until the pop at the end of byte 0's frame, then byte 9 is accepted.
  - Output order is 0..9.
- Reset mid-frame: assert rst asynchronously during bit 3 of 0x00 with 3 bytes queued → tx=1 the same cycle, fifo_count=0. After release, no residual frame is emitted.
- With UART_TX_PARITY_EN:
  - Send 0x07 → parity bit 1 between data and stop; frame 11*CLK_DIV cycles.
  - Send 0x03 → parity bit 0.
